// File: rtl/mesh_local_ni_pkg.sv
// rtl/mesh_local_ni_pkg.sv - shared types and widths for the mesh local network interface
package mesh_local_ni_pkg;

  localparam int CS        = 2;
  localparam int PAYLOAD_W = 24;
  localparam int PL        = 1 + 4*CS + PAYLOAD_W;

  // Field order matches the wire format: valid is the first (most significant) bit.
  typedef struct packed {
    logic                 valid;
    logic [CS-1:0]        dest_x;
    logic [CS-1:0]        dest_y;
    logic [CS-1:0]        src_x;
    logic [CS-1:0]        src_y;
    logic [PAYLOAD_W-1:0] payload;
  } noc_pkt_t;

  typedef enum logic [1:0] {IDLE, WAIT, SEND} ni_state_e;

  function automatic noc_pkt_t make_pkt(input logic [CS-1:0] dx, input logic [CS-1:0] dy,
                                        input logic [CS-1:0] sx, input logic [CS-1:0] sy,
                                        input logic [PAYLOAD_W-1:0] pl);
    noc_pkt_t p;
    p.valid   = 1'b1;
    p.dest_x  = dx;
    p.dest_y  = dy;
    p.src_x   = sx;
    p.src_y   = sy;
    p.payload = pl;
    return p;
  endfunction

endpackage

// File: rtl/mesh_local_ni_if.sv
// rtl/mesh_local_ni_if.sv - core and router side handshake bundle of the local network interface
interface mesh_local_ni_if;
  import mesh_local_ni_pkg::*;

  logic                 tx_valid;
  logic                 tx_ready;
  logic [CS-1:0]        tx_dest_x;
  logic [CS-1:0]        tx_dest_y;
  logic [PAYLOAD_W-1:0] tx_payload;
  noc_pkt_t             pkt_out;
  logic                 avail_in;
  noc_pkt_t             pkt_in;
  logic                 avail_out;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [CS-1:0]        rx_src_x;
  logic [CS-1:0]        rx_src_y;
  logic [PAYLOAD_W-1:0] rx_payload;

  // The NI itself.
  modport slave (
    input  tx_valid, tx_dest_x, tx_dest_y, tx_payload, avail_in, pkt_in, rx_ready,
    output tx_ready, pkt_out, avail_out, rx_valid, rx_src_x, rx_src_y, rx_payload
  );

  // Core plus router, seen from outside the NI.
  modport master (
    output tx_valid, tx_dest_x, tx_dest_y, tx_payload, avail_in, pkt_in, rx_ready,
    input  tx_ready, pkt_out, avail_out, rx_valid, rx_src_x, rx_src_y, rx_payload
  );

endinterface

// File: rtl/mesh_local_ni_fifo.sv
// rtl/mesh_local_ni_fifo.sv - show-ahead synchronous FIFO used on the ejection path
module mesh_local_ni_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          push_en;
  logic          pop_en;

  // A push into a full FIFO is refused even when a pop frees a slot on the same edge.
  assign push_en   = push && !full;
  assign pop_en    = pop && !empty;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem[rptr_q];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_en) mem[wptr_q] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + AW'(1);
      if (pop_en)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(push_en) - CW'(pop_en);
    end
  end

endmodule

// File: rtl/mesh_local_ni.sv
// rtl/mesh_local_ni.sv - local-port network interface: packet injection FSM and ejection FIFO
module mesh_local_ni
  import mesh_local_ni_pkg::*;
#(
  parameter int EJ_DEPTH  = 4,
  parameter int STALL_LIM = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CS-1:0]   node_x,
  input  logic [CS-1:0]   node_y,
  mesh_local_ni_if.slave  ni,
  output logic            stall_err,
  output logic            ovf_err
);

  localparam int WCW = $clog2(STALL_LIM + 1);
  localparam int FW  = 2*CS + PAYLOAD_W;
  localparam int ECW = $clog2(EJ_DEPTH) + 1;

  ni_state_e      state_q, state_d;
  noc_pkt_t       pkt_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           stall_q;
  logic           ovf_q;
  logic [FW-1:0]  ej_head;
  logic           ej_empty;
  logic           ej_full;
  logic [ECW-1:0] ej_count;
  logic           unused_dest;

  // Injection state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus tx_ready/pkt_out decode; the packet is on the wire only in SEND.
  always_comb begin
    state_d     = state_q;
    ni.tx_ready = 1'b0;
    ni.pkt_out  = '0;
    unique case (state_q)
      IDLE: begin
        ni.tx_ready = 1'b1;
        if (ni.tx_valid) state_d = WAIT;
      end
      WAIT: begin
        if (ni.avail_in) state_d = SEND;
      end
      SEND: begin
        ni.pkt_out = pkt_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the request and count wait cycles; the counter saturates so stall_err stays meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q      <= '0;
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else if (state_q == IDLE && ni.tx_valid) begin
      pkt_q      <= make_pkt(ni.tx_dest_x, ni.tx_dest_y, node_x, node_y, ni.tx_payload);
      wait_cnt_q <= '0;
    end else if (state_q == WAIT && !ni.avail_in) begin
      if (wait_cnt_q != WCW'(STALL_LIM)) wait_cnt_q <= wait_cnt_q + WCW'(1);
      if (wait_cnt_q >= WCW'(STALL_LIM - 1)) stall_q <= 1'b1;
    end
  end

  // Sticky overflow flag: any arrival that finds the FIFO full is lost.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (ni.pkt_in.valid && ej_full) ovf_q <= 1'b1;
  end

  // Ejected packets are addressed to this node, so the destination is not stored.
  assign unused_dest = ^{ni.pkt_in.dest_x, ni.pkt_in.dest_y};

  mesh_local_ni_fifo #(
    .W     (FW),
    .DEPTH (EJ_DEPTH)
  ) u_ej_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ni.pkt_in.valid),
    .push_data ({ni.pkt_in.src_x, ni.pkt_in.src_y, ni.pkt_in.payload}),
    .pop       (ni.rx_ready),
    .head_data (ej_head),
    .empty     (ej_empty),
    .full      (ej_full),
    .count     (ej_count)
  );

  assign ni.avail_out  = (ej_count != ECW'(EJ_DEPTH));
  assign ni.rx_valid   = !ej_empty;
  assign ni.rx_src_x   = ej_head[FW-1 -: CS];
  assign ni.rx_src_y   = ej_head[FW-CS-1 -: CS];
  assign ni.rx_payload = ej_head[PAYLOAD_W-1:0];
  assign stall_err     = stall_q;
  assign ovf_err       = ovf_q;

endmodule
